core_link_channel: RTL and testbench



---
 rtl/core_link_pkg.sv | 11 +
 rtl/core_link_channel_if.sv | 13 +
 rtl/link_fifo.sv | 34 +++
 rtl/core_link_channel.sv | 73 +++++++
 tb/tb_core_link_channel.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/core_link_pkg.sv
// core_link_pkg: shared width and status-bit layout for the inter-core link channel
package core_link_pkg;
    localparam int LINK_W = 14;
    localparam int STAT_ECHO = 0;
    localparam int STAT_FULL = 1;
    localparam int STAT_EMPTY = 2;
    localparam int STAT_VALID = 0;
    localparam int STAT_UFLOW = 2;
    localparam int STAT_CNT_LSB = 3;
    localparam int STAT_CNT_MSB = 6;
endpackage

// File: rtl/core_link_channel_if.sv
// core_link_channel_if: sender/receiver port bundle; master is the core side, slave the channel
interface core_link_channel_if #(
    parameter int W = core_link_pkg::LINK_W
);
    logic [W-1:0] tx_data;
    logic [W-1:0] tx_ctrl;
    logic [W-1:0] tx_stat;
    logic [W-1:0] rx_data;
    logic [W-1:0] rx_stat;
    logic [W-1:0] rx_ctrl;
    modport master (output tx_data, tx_ctrl, rx_ctrl, input tx_stat, rx_data, rx_stat);
    modport slave (input tx_data, tx_ctrl, rx_ctrl, output tx_stat, rx_data, rx_stat);
endinterface

// File: rtl/link_fifo.sv
// link_fifo: power-of-two FIFO with push/pop strobes, registered count and a zeroed head when empty
module link_fifo #(
    parameter int DEPTH = 8,
    parameter int W = 14
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    always_ff @(posedge clk)
        if (push) mem[wptr] <= wdata;
    always_ff @(posedge clk)
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop) rptr <= rptr + AW'(1);
            if (push != pop) count <= push ? count + (AW+1)'(1) : count - (AW+1)'(1);
        end
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign rdata = empty ? '0 : mem[rptr];
endmodule

// File: rtl/core_link_channel.sv
// core_link_channel: toggle-handshake word channel between two cores; LINK_INREG_EN registers the inputs first
module core_link_channel
    import core_link_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W = LINK_W
) (
    input logic Clock_pin,
    input logic Resetn_pin,
    core_link_channel_if.slave link
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] tx_d, head;
    logic tx_t, rx_t, push_echo, pop_echo, uflow, full, empty, push, pop, push_pend, pop_pend;
    logic [AW:0] count;
    logic unused;
    assign unused = ^{link.tx_ctrl[W-1:1], link.rx_ctrl[W-1:1]};
`ifdef LINK_INREG_EN
    always_ff @(posedge Clock_pin)
        if (!Resetn_pin) begin
            tx_d <= '0;
            tx_t <= 1'b0;
            rx_t <= 1'b0;
        end else begin
            tx_d <= link.tx_data;
            tx_t <= link.tx_ctrl[0];
            rx_t <= link.rx_ctrl[0];
        end
`else
    assign tx_d = link.tx_data;
    assign tx_t = link.tx_ctrl[0];
    assign rx_t = link.rx_ctrl[0];
`endif
    assign push_pend = tx_t != push_echo;
    assign pop_pend = rx_t != pop_echo;
    assign pop = pop_pend && !empty;
    // a same-cycle pop frees the slot, so a push at full still lands
    assign push = push_pend && (!full || pop);
    link_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
        .clk(Clock_pin),
        .rst_n(Resetn_pin),
        .push(push),
        .pop(pop),
        .wdata(tx_d),
        .rdata(head),
        .count(count),
        .full(full),
        .empty(empty)
    );
    always_ff @(posedge Clock_pin)
        if (!Resetn_pin) begin
            push_echo <= 1'b0;
            pop_echo <= 1'b0;
            uflow <= 1'b0;
        end else begin
            if (push) push_echo <= tx_t;
            if (pop_pend) pop_echo <= rx_t;
            if (pop_pend && empty) uflow <= 1'b1;
        end
    always_comb begin
        link.tx_stat = '0;
        link.tx_stat[STAT_ECHO] = push_echo;
        link.tx_stat[STAT_FULL] = full;
        link.tx_stat[STAT_EMPTY] = empty;
        link.tx_stat[STAT_CNT_MSB:STAT_CNT_LSB] = 4'(count);
        link.rx_stat = '0;
        link.rx_stat[STAT_VALID] = !empty;
        link.rx_stat[STAT_ECHO+1] = pop_echo;
        link.rx_stat[STAT_UFLOW] = uflow;
        link.rx_stat[STAT_CNT_MSB:STAT_CNT_LSB] = 4'(count);
    end
    assign link.rx_data = head;
endmodule

// File: tb/tb_core_link_channel.sv
// tb_core_link_channel: vector table, corner sequences and randomized run against a queue model
module tb_core_link_channel;
    import core_link_pkg::*;
    localparam int DEPTH = 8;
`ifdef LINK_INREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    typedef logic [LINK_W-1:0] word_t;
    typedef struct {
        bit rstn;
        bit tx_t;
        word_t tx_d;
        bit rx_t;
        word_t tx_stat;
        word_t rx_stat;
        word_t rx_data;
    } vec_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic drv_tx_t = 1'b0;
    logic drv_rx_t = 1'b0;
    word_t drv_tx_d = '0;
    int tests = 0;
    int fails = 0;

    core_link_channel_if #(.W(LINK_W)) link ();
    core_link_channel #(.DEPTH(DEPTH), .W(LINK_W)) dut (
        .Clock_pin(clk),
        .Resetn_pin(rstn),
        .link(link)
    );
    assign link.tx_data = drv_tx_d;
    assign link.tx_ctrl = {{(LINK_W-1){1'b0}}, drv_tx_t};
    assign link.rx_ctrl = {{(LINK_W-1){1'b0}}, drv_rx_t};
    always #5 clk = ~clk;

    word_t q[$];
    bit m_pecho, m_oecho, m_uf, r_tx_t, r_rx_t;
    word_t r_tx_d;

    task automatic model_step();
        bit et, er, was_empty, pop_pend, pop_do, push_do;
        word_t ed;
        if (!rstn) begin
            q.delete();
            m_pecho = 0;
            m_oecho = 0;
            m_uf = 0;
            r_tx_t = 0;
            r_rx_t = 0;
            r_tx_d = '0;
            return;
        end
        et = (LAT == 2) ? r_tx_t : drv_tx_t;
        er = (LAT == 2) ? r_rx_t : drv_rx_t;
        ed = (LAT == 2) ? r_tx_d : drv_tx_d;
        r_tx_t = drv_tx_t;
        r_rx_t = drv_rx_t;
        r_tx_d = drv_tx_d;
        was_empty = q.size() == 0;
        pop_pend = er != m_oecho;
        pop_do = pop_pend && !was_empty;
        push_do = (et != m_pecho) && (q.size() < DEPTH || pop_do);
        if (pop_pend) begin
            m_oecho = er;
            if (was_empty) m_uf = 1;
        end
        if (pop_do) void'(q.pop_front());
        if (push_do) begin
            q.push_back(ed);
            m_pecho = et;
        end
    endtask

    function automatic word_t exp_tx();
        int n = q.size();
        return LINK_W'({n[3:0], n == 0, n == DEPTH, m_pecho});
    endfunction
    function automatic word_t exp_rx();
        int n = q.size();
        return LINK_W'({n[3:0], m_uf, m_oecho, n != 0});
    endfunction
    function automatic word_t exp_data();
        return q.size() != 0 ? q[0] : '0;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask
    task automatic check(string name, word_t got, word_t exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, got, exp);
        end
    endtask
    task automatic cmp_model(string tag);
        check({tag, " tx_stat"}, link.tx_stat, exp_tx());
        check({tag, " rx_stat"}, link.rx_stat, exp_rx());
        check({tag, " rx_data"}, link.rx_data, exp_data());
    endtask
    task automatic push(word_t d);
        drv_tx_d = d;
        drv_tx_t = ~drv_tx_t;
        repeat (LAT) tick();
    endtask
    task automatic pop();
        drv_rx_t = ~drv_rx_t;
        repeat (LAT) tick();
    endtask
    task automatic do_reset();
        rstn = 0;
        drv_tx_t = 0;
        drv_rx_t = 0;
        drv_tx_d = '0;
        tick();
        rstn = 1;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vt[7];
        bit old;
        vt[0] = '{0, 0, 14'h000, 0, 14'h0004, 14'h0000, 14'h0000};
        vt[1] = '{1, 1, 14'h1A5, 0, 14'h0009, 14'h0009, 14'h01A5};
        vt[2] = '{1, 1, 14'h1A5, 1, 14'h0005, 14'h0002, 14'h0000};
        vt[3] = '{1, 1, 14'h1A5, 0, 14'h0005, 14'h0004, 14'h0000};
        vt[4] = '{1, 0, 14'h02B, 0, 14'h0008, 14'h000D, 14'h002B};
        vt[5] = '{0, 0, 14'h000, 0, 14'h0004, 14'h0000, 14'h0000};
        vt[6] = '{1, 0, 14'h000, 0, 14'h0004, 14'h0000, 14'h0000};
        for (int i = 0; i < 7; i++) begin
            rstn = vt[i].rstn;
            drv_tx_t = vt[i].tx_t;
            drv_tx_d = vt[i].tx_d;
            drv_rx_t = vt[i].rx_t;
            repeat (LAT) tick();
            check($sformatf("vec%0d tx_stat", i), link.tx_stat, vt[i].tx_stat);
            check($sformatf("vec%0d rx_stat", i), link.rx_stat, vt[i].rx_stat);
            check($sformatf("vec%0d rx_data", i), link.rx_data, vt[i].rx_data);
        end

        do_reset();
        drv_tx_d = 14'h1A5;
        drv_tx_t = 1;
        for (int k = 1; k <= LAT; k++) begin
            tick();
            check($sformatf("latency valid@%0d", k), LINK_W'(link.rx_stat[0]), LINK_W'(k == LAT));
        end
        check("single tx_stat", link.tx_stat, 14'h0009);
        check("single rx_data", link.rx_data, 14'h01A5);
        pop();
        check("single pop rx_stat", link.rx_stat, 14'h0002);
        check("single pop tx_stat", link.tx_stat, 14'h0005);

        do_reset();
        for (int i = 1; i <= DEPTH; i++) push(word_t'(i));
        check("fill full", LINK_W'(link.tx_stat[1]), 14'h1);
        check("fill count", LINK_W'(link.tx_stat[6:3]), 14'd8);
        old = drv_tx_t;
        push(14'h3FFF);
        tick();
        check("held echo", LINK_W'(link.tx_stat[0]), LINK_W'(old));
        check("held count", LINK_W'(link.tx_stat[6:3]), 14'd8);
        pop();
        check("pop+push count", LINK_W'(link.tx_stat[6:3]), 14'd8);
        check("pop+push echo", LINK_W'(link.tx_stat[0]), LINK_W'(drv_tx_t));
        for (int i = 2; i <= DEPTH; i++) begin
            check($sformatf("drain %0d", i), link.rx_data, word_t'(i));
            pop();
        end
        check("drain last", link.rx_data, 14'h3FFF);
        pop();
        cmp_model("drained");

        push(14'h100);
        push(14'h101);
        push(14'h102);
        for (int i = 0; i < 10; i++) begin
            drv_tx_d = word_t'(14'h103 + i);
            drv_tx_t = ~drv_tx_t;
            drv_rx_t = ~drv_rx_t;
            repeat (LAT) tick();
            check($sformatf("simul%0d count", i), LINK_W'(link.tx_stat[6:3]), 14'd3);
            check($sformatf("simul%0d echoes", i), LINK_W'({link.tx_stat[0], link.rx_stat[1]}), LINK_W'({drv_tx_t, drv_rx_t}));
            check($sformatf("simul%0d head", i), link.rx_data, word_t'(14'h101 + i));
        end

        do_reset();
        pop();
        check("uflow set", LINK_W'(link.rx_stat[2]), 14'h1);
        push(14'h055);
        push(14'h066);
        check("uflow sticky", LINK_W'(link.rx_stat[2]), 14'h1);
        cmp_model("uflow stream");
        do_reset();
        check("midreset tx_stat", link.tx_stat, 14'h0004);
        check("midreset rx_stat", link.rx_stat, 14'h0000);
        check("midreset rx_data", link.rx_data, 14'h0000);

        for (int c = 0; c < 3000; c++) begin
            int bias = (c / 400) % 2;
            if (drv_tx_t == m_pecho && $urandom_range(3, 0) < (bias ? 3 : 1)) begin
                drv_tx_d = word_t'($urandom);
                drv_tx_t = ~drv_tx_t;
            end
            if (drv_rx_t == m_oecho && $urandom_range(3, 0) < (bias ? 1 : 3)) drv_rx_t = ~drv_rx_t;
            tick();
            cmp_model($sformatf("rand%0d", c));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
